// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared widths, requester ids and tag-pipe entry for the AES issue scheduler.
package aes_sched_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES_LAT_DEFAULT = 21;
  // Tag field width in the pipe entry; the scheduler's TAG_W must not exceed it.
  localparam int TAG_W_DEF = 4;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
  typedef struct packed {
    logic                 valid;
    req_id_e              id;
    logic [TAG_W_DEF-1:0] tag;
  } tp_entry_t;
endpackage

// File: rtl/aes_issue_sched_if.sv
// aes_issue_sched_if: requester, core and response signals of the AES issue scheduler.
interface aes_issue_sched_if
  import aes_sched_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int AES_LAT = AES_LAT_DEFAULT
);
  logic                         a_valid, a_ready, b_valid, b_ready;
  logic [AES_BLK_W-1:0]         a_state, a_key, b_state, b_key;
  logic [TAG_W-1:0]             a_tag, b_tag;
  logic [AES_BLK_W-1:0]         core_state, core_key, core_out;
  logic                         a_rsp_valid, b_rsp_valid;
  logic [AES_BLK_W-1:0]         a_rsp_data, b_rsp_data;
  logic [TAG_W-1:0]             a_rsp_tag, b_rsp_tag;
  logic [$clog2(AES_LAT+1)-1:0] inflight;
  modport slave (
    input  a_valid, a_state, a_key, a_tag, b_valid, b_state, b_key, b_tag, core_out,
    output a_ready, b_ready, core_state, core_key,
           a_rsp_valid, a_rsp_data, a_rsp_tag, b_rsp_valid, b_rsp_data, b_rsp_tag, inflight
  );
  modport master (
    output a_valid, a_state, a_key, a_tag, b_valid, b_state, b_key, b_tag, core_out,
    input  a_ready, b_ready, core_state, core_key,
           a_rsp_valid, a_rsp_data, a_rsp_tag, b_rsp_valid, b_rsp_data, b_rsp_tag, inflight
  );
endinterface

// File: rtl/aes_sched_tagpipe.sv
// aes_sched_tagpipe: DEPTH-stage shift register of {valid, id, tag} entries tracking in-flight blocks.
module aes_sched_tagpipe
  import aes_sched_pkg::*;
#(
  parameter int DEPTH = AES_LAT_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  tp_entry_t i_entry,
  output tp_entry_t o_tail
);
  tp_entry_t r_pipe [DEPTH];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_entry;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign o_tail = r_pipe[DEPTH-1];
endmodule

// File: rtl/aes_issue_sched.sv
// aes_issue_sched: round-robin sharing of one pipelined aes_128 core between requesters A and B.
// Optional AES_ISSUE_SCHED_STATS_EN adds per-requester 16-bit accepted-request counters.
module aes_issue_sched
  import aes_sched_pkg::*;
#(
  parameter int AES_LAT = AES_LAT_DEFAULT,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  aes_issue_sched_if.slave bus
`ifdef AES_ISSUE_SCHED_STATS_EN
  ,
  output logic [15:0]      a_issued,
  output logic [15:0]      b_issued
`endif
);
  localparam int IW = $clog2(AES_LAT + 1);
  logic                 r_rr;
  logic [AES_BLK_W-1:0] r_core_state, r_core_key;
  logic                 r_a_rsp_valid, r_b_rsp_valid;
  logic [TAG_W-1:0]     r_rsp_tag;
  logic [IW-1:0]        r_inflight;
  logic                 w_a_go, w_b_go, w_go;
  logic [IW-1:0]        w_inflight_nxt;
  tp_entry_t            w_in, w_tail;
  assign bus.a_ready = !bus.b_valid | !r_rr;
  assign bus.b_ready = !bus.a_valid | r_rr;
  assign w_a_go = bus.a_valid & bus.a_ready;
  assign w_b_go = bus.b_valid & bus.b_ready;
  assign w_go   = w_a_go | w_b_go;
  always_comb begin
    w_in.valid = w_go;
    w_in.id    = w_b_go ? REQ_B : REQ_A;
    w_in.tag   = w_b_go ? TAG_W_DEF'(bus.b_tag) : TAG_W_DEF'(bus.a_tag);
  end
  aes_sched_tagpipe #(.DEPTH(AES_LAT)) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .i_entry (w_in),
    .o_tail  (w_tail)
  );
  // Tail leaves the pipe on the edge the core output becomes valid, so it is counted returned there.
  always_comb
    w_inflight_nxt = (w_go && !w_tail.valid) ? r_inflight + IW'(1) :
                     (!w_go && w_tail.valid) ? r_inflight - IW'(1) : r_inflight;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr          <= 1'b0;
      r_core_state  <= '0;
      r_core_key    <= '0;
      r_a_rsp_valid <= 1'b0;
      r_b_rsp_valid <= 1'b0;
      r_rsp_tag     <= '0;
      r_inflight    <= '0;
    end else begin
      if (w_go) begin
        r_rr         <= w_a_go;
        r_core_state <= w_a_go ? bus.a_state : bus.b_state;
        r_core_key   <= w_a_go ? bus.a_key : bus.b_key;
      end
      r_a_rsp_valid <= w_tail.valid && w_tail.id == REQ_A;
      r_b_rsp_valid <= w_tail.valid && w_tail.id == REQ_B;
      r_rsp_tag     <= TAG_W'(w_tail.tag);
      r_inflight    <= w_inflight_nxt;
    end
  end
  assign bus.core_state  = r_core_state;
  assign bus.core_key    = r_core_key;
  assign bus.a_rsp_valid = r_a_rsp_valid;
  assign bus.b_rsp_valid = r_b_rsp_valid;
  assign bus.a_rsp_data  = bus.core_out;
  assign bus.b_rsp_data  = bus.core_out;
  assign bus.a_rsp_tag   = r_rsp_tag;
  assign bus.b_rsp_tag   = r_rsp_tag;
  assign bus.inflight    = r_inflight;
`ifdef AES_ISSUE_SCHED_STATS_EN
  logic [15:0] r_a_issued, r_b_issued;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_issued <= '0;
      r_b_issued <= '0;
    end else begin
      if (w_a_go) r_a_issued <= r_a_issued + 16'd1;
      if (w_b_go) r_b_issued <= r_b_issued + 16'd1;
    end
  end
  assign a_issued = r_a_issued;
  assign b_issued = r_b_issued;
`endif
endmodule

// File: doc/aes_issue_sched.md
# aes_issue_sched

- Shares one fully pipelined `aes_128` core between two requesters, A and B.
- Each requester hands over a plaintext/key/tag with a valid/ready handshake.
- The block arbitrates round-robin, registers the winner onto the core inputs, and tracks every in-flight block through a tag pipeline matched to the core latency.
- It routes the core output back to the issuing requester's response port.
- It sits between the requester logic and `aes_128` in `top`, replacing the direct `state`/`key` connection.

## Interface
Parameters:
- AES_LAT, 21: clock edges from core input change to matching `core_out`.
- TAG_W, 4: width of the requester-supplied tag, returned unchanged with the result.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_valid / b_valid  in  1  request present.
- a_ready / b_ready  out  1  request accepted when valid&ready at an edge.
- a_state / b_state  in  128  plaintext block.
- a_key / b_key  in  128  cipher key.
- a_tag / b_tag  in  TAG_W  opaque tag.
- core_state  out  128  to `aes_128` state input, registered.
- core_key  out  128  to `aes_128` key input, registered.
- core_out  in  128  from `aes_128` output.
- a_rsp_valid / b_rsp_valid  out  1  one-cycle result strobe; there is no backpressure.
- a_rsp_data / b_rsp_data  out  128  ciphertext, equal to `core_out`.
- a_rsp_tag / b_rsp_tag  out  TAG_W  tag of the returned block.
- inflight  out  $clog2(AES_LAT+1)  number of blocks issued and not yet returned.

## Operation
Arbitration:
- A 1-bit round-robin pointer `rr` selects the favoured requester (0=A, 1=B).
- a_ready = !b_valid | (rr==0).
- b_ready = !a_valid | (rr==1).
- When both are valid, exactly one is ready. When neither is valid, both are ready and no transfer occurs.
- After each granted transfer, `rr` points to the non-granted requester. With no transfer, `rr` holds.
- A lone requester is granted every cycle, giving a throughput of one block per cycle.

Issue:
- On a transfer, `core_state`/`core_key` load the winner's block at that edge.
- With no transfer, they hold their previous values. Idle cycles never create a tag entry.

Tag pipeline:
- AES_LAT stages of {valid, id, tag}. The entry shifts in at the issue edge.
- When the stage-AES_LAT entry is valid, the matching rsp_valid is high for that cycle with data = `core_out` and tag = entry tag. The other port's rsp_valid stays low.
- rsp_data ports always show `core_out`; they are meaningful only while the matching rsp_valid is high.

inflight:
- Increments on issue and decrements on return.
- Both on the same edge: unchanged.
- Maximum value is AES_LAT, because issue never stalls.

## Timing
- Reset (rst low, asynchronous):
  - rr=0.
  - core_state=0, core_key=0.
  - All tag-pipe valids=0, rsp_valid=0, inflight=0, stats counters=0.
  - ready outputs follow the valid inputs as normal.
- Reset mid-operation: all in-flight blocks are dropped, and no response ever appears for them.
- Latency: a handshake at edge E gives a response during the cycle after edge E+AES_LAT.
- Back-to-back issues return back-to-back in issue order, including interleaved A/B traffic.
- Requesters must hold valid/state/key/tag stable until the handshake completes.

## Configuration
- AES_ISSUE_SCHED_STATS_EN defined:
  - Adds ports `a_issued` and `b_issued` (out, 16 bits each).
  - Each is a count of accepted requests, incremented on its own handshake edge.
  - Each wraps from 0xFFFF to 0x0000 and is reset to 0.
- Not defined: the ports and counters are absent, and there is no other behavioural difference.

## Structure
- Package `aes_sched_pkg`:
  - AES_BLK_W=128.
  - Default AES_LAT=21.
  - Requester-id typedef (REQ_A=0, REQ_B=1).
  - Tag-pipe entry struct {valid, id, tag}.
- Sub-module `aes_sched_tagpipe`:
  - Parameterized shift register of entries, depth AES_LAT, with async active-low reset.
  - Outputs its tail entry.
  - The arbiter, issue registers, inflight counter and stats stay in the top block.

## Test plan
- FIPS-197 vector on A: key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff, tag 3 -> a_rsp_valid exactly 21 cycles later with data 69c4e0d86a7b0430d8cdb78070b4c55a and tag 3; b_rsp_valid never asserts.
- A and B both valid continuously for 8 cycles, after reset with rr=0 -> grants alternate A,B,A,B…; each port gets 4 responses in issue order; inflight peaks at 8.
- B alone valid for 30 cycles -> b_ready high every cycle; 30 responses arrive on consecutive cycles starting 21 cycles after the first handshake; inflight saturates at 21.
- rst pulsed low while 5 blocks are in flight -> inflight=0 and all rsp_valid low immediately; no responses appear afterwards; core_state reads 0.
- Idle gaps: A issues at cycles 0 and 5 with nothing in between -> exactly two responses at cycles 21 and 26; core_state holds the cycle-0 block through cycles 1–4.
- With AES_ISSUE_SCHED_STATS_EN: 65537 A handshakes -> a_issued=0x0001, b_issued=0.
